// File: rtl/output_mode_sequencer.sv
// output_mode_sequencer: break-before-make sequencing of the
// PWM / R2R / buzzer output enables from a push button or host request.
module output_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEAD_CYCLES     = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_raw,
    input  logic       sel_valid,
    input  logic [1:0] sel_mode,
    output logic       sel_ready,
    output logic [1:0] mode,
    output logic       pwm_enable,
    output logic       r2r_enable,
    output logic       buzzer_enable,
    output logic       busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int DT_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD_CYCLES - 1);

    typedef enum logic {
        ST_ACTIVE,
        ST_SWITCH
    } state_t;

    state_t            r_state;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_deb_level;
    logic              r_deb_prev;
    logic [DB_W-1:0]   r_deb_cnt;
    logic [DT_W-1:0]   r_dead_cnt;
    logic [1:0]        r_mode;
    logic [1:0]        r_target;
    logic [2:0]        r_en;
    logic              r_busy;

    logic              w_press;
    logic              w_req_valid;
    logic [1:0]        w_req_mode;

    // One-hot enable pattern {pwm, r2r, buzzer} for a mode
    function automatic logic [2:0] en_of(input logic [1:0] m);
        logic [2:0] e;
        case (m)
            2'b01:   e = 3'b100;
            2'b10:   e = 3'b010;
            2'b11:   e = 3'b001;
            default: e = 3'b000;
        endcase
        return e;
    endfunction

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: level flips after a run of consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_deb_level <= 1'b0;
            r_deb_prev  <= 1'b0;
            r_deb_cnt   <= '0;
        end else begin
            r_deb_prev <= r_deb_level;
            if (r_sync2 != r_deb_level) begin
                if (r_deb_cnt == DB_LAST) begin
                    r_deb_level <= ~r_deb_level;
                    r_deb_cnt   <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DB_W'(1);
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    assign w_press = r_deb_level & ~r_deb_prev;

    // Host request has priority; a simultaneous press is dropped
    always_comb begin
        w_req_valid = 1'b0;
        w_req_mode  = r_mode;
        if (sel_valid) begin
            w_req_valid = 1'b1;
            w_req_mode  = sel_mode;
        end else if (w_press) begin
            w_req_valid = 1'b1;
            w_req_mode  = r_mode + 2'd1;
        end
    end

    // Mode FSM: hold all enables low for the dead time on a change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_ACTIVE;
            r_mode     <= 2'b00;
            r_target   <= 2'b00;
            r_dead_cnt <= '0;
            r_en       <= 3'b000;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                ST_ACTIVE: begin
                    if (w_req_valid && (w_req_mode != r_mode)) begin
                        r_state    <= ST_SWITCH;
                        r_target   <= w_req_mode;
                        r_dead_cnt <= DT_LOAD;
                        r_en       <= 3'b000;
                        r_busy     <= 1'b1;
                    end else begin
                        r_en <= en_of(r_mode);
                    end
                end
                ST_SWITCH: begin
                    if (r_dead_cnt == '0) begin
                        r_state <= ST_ACTIVE;
                        r_mode  <= r_target;
                        r_en    <= en_of(r_target);
                        r_busy  <= 1'b0;
                    end else begin
                        r_dead_cnt <= r_dead_cnt - DT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_ACTIVE;
                end
            endcase
        end
    end

    assign sel_ready     = (r_state == ST_ACTIVE);
    assign mode          = r_mode;
    assign pwm_enable    = r_en[2];
    assign r2r_enable    = r_en[1];
    assign buzzer_enable = r_en[0];
    assign busy          = r_busy;

endmodule

// File: tb/tb_output_mode_sequencer.sv
// tb_output_mode_sequencer: vector table, directed corner sequences
// and random traffic checked against a cycle-level behavioural model.
module tb_output_mode_sequencer;

    localparam int DEB  = 4;
    localparam int DEAD = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_raw = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_mode = 2'b00;
    logic       sel_ready;
    logic [1:0] mode;
    logic       pwm_enable;
    logic       r2r_enable;
    logic       buzzer_enable;
    logic       busy;

    int errors = 0;
    int checks = 0;

    output_mode_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .DEAD_CYCLES(DEAD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_raw(btn_raw),
        .sel_valid(sel_valid),
        .sel_mode(sel_mode),
        .sel_ready(sel_ready),
        .mode(mode),
        .pwm_enable(pwm_enable),
        .r2r_enable(r2r_enable),
        .buzzer_enable(buzzer_enable),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int m_mode;
    int m_target;
    int m_dead;
    bit m_r1;
    bit m_r2;
    bit m_deb;
    int m_run;
    bit m_press;

    typedef struct {
        bit       v;
        bit [1:0] m;
        bit [1:0] emode;
        bit       ebusy;
        bit [2:0] een;
    } vec_t;

    vec_t tbl[10];

    function automatic void model_reset();
        m_mode   = 0;
        m_target = 0;
        m_dead   = 0;
        m_r1     = 0;
        m_r2     = 0;
        m_deb    = 0;
        m_run    = 0;
        m_press  = 0;
    endfunction

    function automatic void model_step();
        bit press_now;
        bit take;
        int req;
        bit synced;
        press_now = m_press;
        m_press   = 0;
        take      = 0;
        req       = m_mode;
        if (m_dead > 0) begin
            m_dead = m_dead - 1;
            if (m_dead == 0) m_mode = m_target;
        end else begin
            if (sel_valid) begin
                take = 1;
                req  = int'(sel_mode);
            end else if (press_now) begin
                take = 1;
                req  = (m_mode + 1) % 4;
            end
            if (take && req != m_mode) begin
                m_target = req;
                m_dead   = DEAD;
            end
        end
        synced = m_r2;
        if (synced != m_deb) begin
            m_run = m_run + 1;
            if (m_run == DEB) begin
                m_deb = !m_deb;
                m_run = 0;
                if (m_deb) m_press = 1;
            end
        end else begin
            m_run = 0;
        end
        m_r2 = m_r1;
        m_r1 = btn_raw;
    endfunction

    function automatic logic [6:0] model_vec();
        logic [2:0] en;
        bit b;
        b  = (m_dead > 0);
        en = 3'b000;
        if (!b) begin
            case (m_mode)
                1: en = 3'b100;
                2: en = 3'b010;
                3: en = 3'b001;
                default: en = 3'b000;
            endcase
        end
        return {~b, 2'(m_mode), en, b};
    endfunction

    function automatic logic [6:0] dut_vec();
        return {sel_ready, mode, pwm_enable,
                r2r_enable, buzzer_enable, busy};
    endfunction

    task automatic cmp(input string name,
                       input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic [1:0] inv;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp("model", {1'b0, dut_vec()}, {1'b0, model_vec()});
        inv[1] = busy && (pwm_enable || r2r_enable || buzzer_enable);
        inv[0] = (int'(pwm_enable) + int'(r2r_enable)
                  + int'(buzzer_enable)) > 1;
        cmp("invariant", {6'b0, inv}, 8'h00);
    endtask

    task automatic check_mode(input string name, input logic [1:0] m);
        cmp(name, {6'b0, mode}, {6'b0, m});
    endtask

    task automatic press_button(input int hold);
        btn_raw = 1'b1;
        repeat (hold) tick();
        btn_raw = 1'b0;
        repeat (12) tick();
    endtask

    task automatic wait_press();
        int n;
        n = 0;
        while (!m_press && n < 30) begin
            tick();
            n++;
        end
        cmp("press_timeout", {7'b0, m_press}, 8'h01);
    endtask

    initial begin
        int hold_left;

        tbl[0] = '{0, 2'd0, 2'd0, 0, 3'b000};
        tbl[1] = '{1, 2'd1, 2'd0, 1, 3'b000};
        tbl[2] = '{0, 2'd0, 2'd0, 1, 3'b000};
        tbl[3] = '{0, 2'd0, 2'd0, 1, 3'b000};
        tbl[4] = '{0, 2'd0, 2'd1, 0, 3'b100};
        tbl[5] = '{1, 2'd1, 2'd1, 0, 3'b100};
        tbl[6] = '{1, 2'd3, 2'd1, 1, 3'b000};
        tbl[7] = '{1, 2'd0, 2'd1, 1, 3'b000};
        tbl[8] = '{0, 2'd0, 2'd1, 1, 3'b000};
        tbl[9] = '{0, 2'd0, 2'd3, 0, 3'b001};

        model_reset();
        repeat (2) @(negedge clk);
        cmp("reset_state", {1'b0, dut_vec()}, {1'b0, 7'b1000000});
        reset_n = 1'b1;

        // Directed vector table: switch to PWM, no-op, switch to BUZZER
        for (int i = 0; i < 10; i++) begin
            sel_valid = tbl[i].v;
            sel_mode  = tbl[i].m;
            tick();
            cmp($sformatf("vec%0d", i), {1'b0, dut_vec()},
                {1'b0, ~tbl[i].ebusy, tbl[i].emode,
                 tbl[i].een, tbl[i].ebusy});
        end
        sel_valid = 1'b0;
        sel_mode  = 2'b00;

        // BUZZER press wraps to OFF
        press_button(10);
        check_mode("wrap_off", 2'd0);

        // 3-cycle glitch is filtered
        btn_raw = 1'b1;
        repeat (3) tick();
        btn_raw = 1'b0;
        repeat (12) tick();
        check_mode("glitch", 2'd0);

        // OFF -> PWM by host, then PWM -> R2R by button
        sel_valid = 1'b1;
        sel_mode  = 2'd1;
        tick();
        sel_valid = 1'b0;
        repeat (6) tick();
        check_mode("host_pwm", 2'd1);
        press_button(10);
        check_mode("btn_r2r", 2'd2);

        // Press coincident with host request: host wins
        btn_raw = 1'b1;
        wait_press();
        sel_valid = 1'b1;
        sel_mode  = 2'd3;
        tick();
        sel_valid = 1'b0;
        repeat (6) tick();
        btn_raw = 1'b0;
        repeat (15) tick();
        check_mode("host_wins", 2'd3);

        // Press landing during SWITCH is dropped
        btn_raw = 1'b1;
        repeat (4) tick();
        sel_valid = 1'b1;
        sel_mode  = 2'd1;
        tick();
        sel_valid = 1'b0;
        repeat (5) tick();
        btn_raw = 1'b0;
        repeat (12) tick();
        check_mode("press_in_switch", 2'd1);

        // Held request during SWITCH accepted once ACTIVE again
        sel_valid = 1'b1;
        sel_mode  = 2'd2;
        tick();
        sel_mode = 2'd3;
        repeat (4) tick();
        sel_valid = 1'b0;
        repeat (6) tick();
        check_mode("held_req", 2'd3);

        // Reset in second dead cycle of a switch to R2R
        sel_valid = 1'b1;
        sel_mode  = 2'd2;
        tick();
        sel_valid = 1'b0;
        tick();
        #2 reset_n = 1'b0;
        #1;
        cmp("async_reset", {1'b0, dut_vec()}, {1'b0, 7'b1000000});
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) tick();
        cmp("post_reset", {1'b0, dut_vec()}, {1'b0, 7'b1000000});

        // Random traffic
        hold_left = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_left == 0) begin
                btn_raw   = ~btn_raw;
                hold_left = $urandom_range(1, 12);
            end
            hold_left--;
            sel_valid = ($urandom_range(0, 7) == 0);
            sel_mode  = 2'($urandom_range(0, 3));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/output_mode_sequencer.md
Name: output_mode_sequencer

Overview:
Controller that sequences the output stage enables (PWM DAC, R2R ladder, buzzer) from a front-panel push button and a host-side mode-select handshake. It guarantees break-before-make switching: the old enable drops, all enables stay low for a programmable dead time, then the new enable rises. At most one enable is ever high, and the block reports the committed mode and a busy flag.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable clk cycles required before a synchronized button level is accepted (>=1).
DEAD_CYCLES, 3, clk cycles during which all enables are held low on a mode change (>=1).

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
btn_raw  input  1  asynchronous push button, active-high; each accepted press advances the mode.
sel_valid  input  1  host mode-change request valid.
sel_mode  input  2  requested mode: 00 OFF, 01 PWM, 10 R2R, 11 BUZZER.
sel_ready  output  1  high when the block can accept a request; sel_valid&&sel_ready = accepted.
mode  output  2  committed mode (encoding as sel_mode).
pwm_enable  output  1  high only when mode==PWM and not switching.
r2r_enable  output  1  high only when mode==R2R and not switching.
buzzer_enable  output  1  high only when mode==BUZZER and not switching.
busy  output  1  high during dead time.

Behaviour:
- Reset (reset_n low, async): state ACTIVE, mode=OFF, target=OFF, all enables 0, busy 0, debounce state cleared (debounced level 0, counter 0), synchronizer flops 0. sel_ready=1 once state is ACTIVE.
- Button path: 2-flop synchronizer, then debounce counter. If the synced level differs from the debounced level, the counter increments; otherwise it clears. At DEBOUNCE_CYCLES consecutive differing cycles, the debounced level flips and the counter clears. A press event is a single-cycle pulse on the debounced 0->1 transition.
- Press -> request for mode (mode+1) mod 4: OFF->PWM->R2R->BUZZER->OFF, 2-bit wrap.
- States: ACTIVE, SWITCH.
- ACTIVE: sel_ready=1, busy=0; the enable for the current mode is high (none if OFF).
- Request arbitration in ACTIVE: sel_valid wins over a simultaneous press; that press is dropped. Presses arriving in SWITCH are dropped, not queued.
- Accepted request equal to current mode: no-op. Stays in ACTIVE, no dead time, enables unchanged.
- Accepted request differing from current mode at cycle t:
  - t+1: state SWITCH, target latched, all enables 0, busy 1, sel_ready 0, dead counter loaded with DEAD_CYCLES-1.
  - Enables stay 0 for exactly DEAD_CYCLES cycles (t+1 .. t+DEAD_CYCLES).
  - At the cycle the counter reads 0, the next edge sets mode=target, state ACTIVE, busy 0.
  - The new enable is high from t+DEAD_CYCLES+1.
  - A switch to OFF follows the same timing; mode changes only after the dead time.
- SWITCH: sel_ready=0; sel_valid is ignored (host must hold the request), and sel_mode changes have no effect.
- All enables, mode and busy are registered outputs. sel_ready is combinational from state.
- Invariant: at most one of pwm/r2r/buzzer_enable is high; whenever busy=1, all are 0.
- Reset mid-SWITCH: immediate return to OFF with all enables 0; the pending target is discarded.
- Counter widths: $clog2(DEBOUNCE_CYCLES+1) and $clog2(DEAD_CYCLES+1) bits; no overflow is possible by construction.

Test Plan:
1. Release reset, then sel_valid=1, sel_mode=01 for one cycle at t -> enables 0 at t+1..t+3 with busy=1; at t+4 pwm_enable=1, mode=01, busy=0.
2. From PWM, btn_raw high for 10 cycles -> one press, detected 2 sync + 4 debounce cycles after the edge -> r2r_enable rises 3 dead cycles later; pwm_enable and r2r_enable are never both high.
3. From BUZZER, one button press -> mode wraps to 00 after 3 dead cycles, all enables 0. Also: btn_raw glitch high for 3 cycles -> no mode change.
4. In PWM, sel_valid with sel_mode=01 -> sel_ready stays 1, busy stays 0, pwm_enable never drops.
5. Press and sel_valid (sel_mode=11) in the same cycle -> result is BUZZER only. Press during SWITCH -> ignored. sel_valid during SWITCH -> sel_ready=0 until the switch completes, then the held request is accepted.
6. Assert reset_n low during the second dead cycle of a switch to R2R -> mode=00 and all enables 0 asynchronously; after release, stays OFF with sel_ready=1.
